// File: rtl/sram_pkg.sv
// Shared types and helpers for the parameterised 1RW1R SRAM model.
package sram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } clear_state_e;

  localparam int MERGE_MAX_WIDTH = 256;
  localparam int MERGE_IDX_W     = $clog2(MERGE_MAX_WIDTH);

  // Replace the bits of every enabled lane of old_word with new_word.
  // Callers zero-extend into the fixed-width container and truncate the result.
  function automatic logic [MERGE_MAX_WIDTH-1:0] lane_merge(
    input logic [MERGE_MAX_WIDTH-1:0] old_word,
    input logic [MERGE_MAX_WIDTH-1:0] new_word,
    input logic [MERGE_MAX_WIDTH-1:0] mask,
    input int                         lane_width
  );
    logic [MERGE_MAX_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MERGE_MAX_WIDTH; b++) begin
      if (mask[MERGE_IDX_W'(b / lane_width)]) begin
        merged[MERGE_IDX_W'(b)] = new_word[MERGE_IDX_W'(b)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: a capture stage plus READ_LATENCY shift stages.
// Data of a stage only moves with its valid bit, so the output holds between strobes.
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int STAGES = READ_LATENCY + 1;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  prev_valid;
    logic [DATA_WIDTH-1:0] prev_data;

    if (i == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_data  = in_data;
    end else begin : g_tail
      assign prev_valid = g_stage[i-1].valid_q;
      assign prev_data  = g_stage[i-1].data_q;
    end

    always_ff @(posedge clk) begin
      if (flush) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= prev_valid;
        if (prev_valid) begin
          data_q <= prev_data;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_data  = g_stage[STAGES-1].data_q;

endmodule

// File: rtl/sky130_sram_1rw1r_param.sv
// Parameterised 1RW1R SRAM with lane-masked writes and pipelined reads.
// Optional macro SRAM_INIT_CLEAR_EN adds a reset-triggered zero-fill sweep.
module sky130_sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int NUM_WMASKS   = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_NEW      = 0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dvalid0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dvalid1,
  output logic                  collide,
  output logic                  busy
);

  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  acc_wr;
  logic                  acc_rd0;
  logic                  acc_rd1;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd1_word;
  logic                  collide_q;

  assign acc_wr    = !rst0 && !busy && !csb0 && !web0;
  assign acc_rd0   = !rst0 && !busy && !csb0 && web0;
  assign acc_rd1   = !rst0 && !busy && !csb1;
  assign same_addr = (addr0 == addr1);

  assign wr_word = DATA_WIDTH'(lane_merge(MERGE_MAX_WIDTH'(mem[addr0]),
                                          MERGE_MAX_WIDTH'(din0),
                                          MERGE_MAX_WIDTH'(wmask0),
                                          LANE_WIDTH));

  // Port 1 sees the pre-write word unless new-data read-during-write is selected.
  assign rd1_word = ((RDW_NEW != 0) && acc_wr && same_addr) ? wr_word : mem[addr1];

`ifdef SRAM_INIT_CLEAR_EN
  clear_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
        state_d = READY;
      end
    end
  end

  assign busy = (state_q == CLEAR);

  always_ff @(posedge clk0) begin
    if (!rst0 && busy) begin
      mem[ptr_q] <= '0;
    end else if (acc_wr) begin
      mem[addr0] <= wr_word;
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk0) begin
    if (acc_wr) begin
      mem[addr0] <= wr_word;
    end
  end
`endif

  always_ff @(posedge clk0) begin
    if (rst0) begin
      collide_q <= 1'b0;
    end else begin
      collide_q <= acc_wr && acc_rd1 && same_addr;
    end
  end

  assign collide = collide_q;

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe0 (
    .clk      (clk0),
    .flush    (rst0),
    .in_valid (acc_rd0),
    .in_data  (mem[addr0]),
    .out_valid(dvalid0),
    .out_data (dout0)
  );

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe1 (
    .clk      (clk0),
    .flush    (rst0),
    .in_valid (acc_rd1),
    .in_data  (rd1_word),
    .out_valid(dvalid1),
    .out_data (dout1)
  );

endmodule

// File: doc/sky130_sram_1rw1r_param.md
SKY130_SRAM_1RW1R_PARAM -- requirements
Module: sky130_sram_1rw1r_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 9: address bits; RAM_DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter NUM_WMASKS, default 4: write-mask lanes; DATA_WIDTH divisible by NUM_WMASKS, lane width = DATA_WIDTH/NUM_WMASKS.
REQ-004 Parameter READ_LATENCY, default 1, legal 1..3: cycles from accepted read to dout.
REQ-005 Parameter RDW_NEW, default 0: same-address read-during-write returns 0 = old data, 1 = new data.
REQ-006 Ports, one clock, synchronous active-high reset: clk0 in 1 clock (all logic on posedge); rst0 in 1 reset, synchronous, active-high.
REQ-007 csb0 in 1, active-low port-0 select; web0 in 1, active-low write enable; wmask0 in NUM_WMASKS, lane enables; addr0 in ADDR_WIDTH; din0 in DATA_WIDTH.
REQ-008 dout0 out DATA_WIDTH, port-0 read data; dvalid0 out 1, dout0 valid strobe.
REQ-009 csb1 in 1, active-low port-1 read select; addr1 in ADDR_WIDTH; dout1 out DATA_WIDTH; dvalid1 out 1.
REQ-010 collide out 1, registered same-address write/read collision flag; busy out 1, requests ignored while high.

Function
REQ-011 A request is accepted at posedge when its csb is 0, busy is 0 and rst0 is 0.
REQ-012 Accepted port-0 write (web0=0) updates lane k of mem[addr0] iff wmask0[k]=1, at that same edge; wmask0 all zero leaves memory unchanged.
REQ-013 Accepted read on either port drives mem data on dout at edge N+READ_LATENCY with dvalid high for exactly one cycle per request.
REQ-014 Read pipelines accept one request per cycle, back-to-back, with no bubbles.
REQ-015 dout holds its last value when dvalid is low; dout never changes except with dvalid.
REQ-016 Port-0 write plus accepted port-1 read to the same address in the same cycle: dout1 returns old word if RDW_NEW=0, merged new word (masked lanes only) if RDW_NEW=1.
REQ-017 Same condition sets collide high for one cycle at edge N+1; different addresses or web0=1 never set collide.
REQ-018 Port-0 write produces no dvalid0 pulse; port-0 read returns whole word regardless of wmask0.
REQ-019 Address wrap: addresses are exactly ADDR_WIDTH bits; no out-of-range case exists.

Reset
REQ-020 rst0 high at posedge clears dout0, dout1 to 0, dvalid0, dvalid1, collide to 0 and flushes all in-flight read pipeline stages (no dvalid for requests in flight).
REQ-021 Without the configuration macro, reset does not alter memory contents and busy is constant 0.

Configuration
REQ-022 Macro SRAM_INIT_CLEAR_EN compiles in a clear sweep: FSM states CLEAR and READY.
REQ-023 With macro: rst0 forces CLEAR, sweep pointer 0, busy 1; each CLEAR cycle writes 0 to mem[ptr] and increments ptr; after writing RAM_DEPTH-1 moves to READY, busy 0 next cycle.
REQ-024 With macro: sweep takes exactly RAM_DEPTH cycles after rst0 falls; rst0 mid-sweep restarts at pointer 0; requests during CLEAR are dropped without dvalid.
REQ-025 Without macro: no FSM, no sweep pointer, busy tied 0, memory uninitialised (X in simulation).

Structure
REQ-026 Shared package sram_pkg holds the clear-FSM state enum and the lane-merge helper function (old word, new word, mask -> merged word).
REQ-027 One sub-module sram_rd_pipe (parameters DATA_WIDTH, READ_LATENCY; valid/data shift pipeline with synchronous flush) is instantiated once per read port.

Verification (DATA_WIDTH=32, ADDR_WIDTH=9, NUM_WMASKS=4)
REQ-028 Write 0xDEADBEEF to 0x010, mask 4'b1111; READ_LATENCY=2 read 0x010 on port 1 -> dout1=0xDEADBEEF, dvalid1 high exactly 2 cycles after request.
REQ-029 Preload 0x11223344 at 0x020; write 0xAABBCCDD mask 4'b0101 -> read returns 0x11BB33DD; mask 4'b0000 -> unchanged.
REQ-030 Same-cycle write 0xCAFEF00D mask 4'b1111 and port-1 read of 0x030 (old 0x0) -> RDW_NEW=0 dout1=0x00000000, RDW_NEW=1 dout1=0xCAFEF00D; collide high one cycle in both.
REQ-031 Reads on consecutive cycles to 0x000..0x007 on both ports -> 8 consecutive dvalid pulses in order, correct data; rst0 asserted with 2 reads in flight -> no further dvalid, dout=0.
REQ-032 With SRAM_INIT_CLEAR_EN: preload 0xFFFFFFFF everywhere, pulse rst0 -> busy high exactly 512 cycles, request during busy yields no dvalid, afterward read 0x1FF -> 0x00000000; rst0 at sweep cycle 100 -> busy another full 512 cycles.
